if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/if_stage_if_id.sv | 33 +++
 rtl/if_stage.sv | 54 +++++
 tb/tb_if_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, control encodings and fetch FSM states for the IF stage
package if_stage_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef enum logic {IDLE, FETCH} fetch_state_e;
  function automatic logic [INST_ADDR_W-1:0] seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + INST_ADDR_W'(4);
  endfunction
endpackage

// File: rtl/if_stage_if_id.sv
// if_id: IF/ID pipeline register with bubble insertion and misaligned-fetch flagging
module if_id
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [5:0]             stall,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic [INST_W-1:0]      inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_adel
);
  logic unused_stall;
  logic bubble;
  logic aligned;
  assign unused_stall = ^{stall[5:3], stall[0]};
  assign bubble = rst == RST_ENABLE || flush || (stall[1] == STOP && stall[2] == NO_STOP);
  assign aligned = pc[1:0] == 2'b00;
  always_ff @(posedge clk) begin
    if (bubble) begin
      id_pc <= '0;
      id_inst <= ZERO_WORD;
      id_adel <= 1'b0;
    end else if (stall[1] == NO_STOP) begin
      id_pc <= pc;
      id_inst <= (ce == CHIP_ENABLE && aligned) ? inst : ZERO_WORD;
      id_adel <= ce == CHIP_ENABLE && !aligned;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC generation and fetch FSM feeding the IF/ID register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_adel
);
  fetch_state_e state, state_nxt;
  logic [INST_ADDR_W-1:0] pc_nxt;
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= IDLE;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
    end
  end
  // IDLE keeps pc at RESET_PC so the first FETCH cycle presents it
  always_comb begin
    state_nxt = FETCH;
    ce = state == FETCH ? CHIP_ENABLE : CHIP_DISABLE;
    pc_nxt = state == IDLE ? RESET_PC
           : flush ? new_pc
           : stall[0] == STOP ? pc
           : branch_flag_i ? branch_target_address_i
           : seq_pc(pc);
  end
  if_id u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .stall(stall),
    .ce(ce),
    .pc(pc),
    .inst(inst_i),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_adel(id_adel)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage
module tb_if_stage;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] stall;
  logic flush;
  logic [31:0] new_pc;
  logic branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] inst_i;
  logic [31:0] pc;
  logic ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic id_adel;
  typedef struct {
    int step;
    logic [31:0] pc;
    logic ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic id_adel;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  always #5 clk = ~clk;
  // ROM: word i at byte address 4*i holds 32'h1000_0000 + i
  assign inst_i = 32'h1000_0000 + (pc >> 2);
  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .inst_i(inst_i),
    .pc(pc),
    .ce(ce),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_adel(id_adel)
  );
  task automatic chk(input string tag, input int s, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL step %0d %s: got %h expected %h", s, tag, got, want);
    end
  endtask
  task automatic step(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                      input logic br, input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_ce,
                      input logic [31:0] e_id_pc, input logic [31:0] e_id_inst, input logic e_adel);
    exp_t e;
    rst = r;
    stall = st;
    flush = fl;
    new_pc = npc;
    branch_flag_i = br;
    branch_target_address_i = tgt;
    step_no++;
    sb.push_back('{step_no, e_pc, e_ce, e_id_pc, e_id_inst, e_adel});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", e.step, pc, e.pc);
    chk("ce", e.step, {31'b0, ce}, {31'b0, e.ce});
    chk("id_pc", e.step, id_pc, e.id_pc);
    chk("id_inst", e.step, id_inst, e.id_inst);
    chk("id_adel", e.step, {31'b0, id_adel}, {31'b0, e.id_adel});
  endtask
  initial begin
    @(negedge clk);
    // reset, with noise on flush/branch that must be ignored
    step(1, 6'b000111, 1, 32'h180, 1, 32'h40, 32'h0, 0, 32'h0, 32'h0, 0);
    step(1, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
    // release: IDLE edge then sequential fetch
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h4, 1, 32'h0, 32'h1000_0000, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h8, 1, 32'h4, 32'h1000_0001, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'hC, 1, 32'h8, 32'h1000_0002, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h10, 1, 32'hC, 32'h1000_0003, 0);
    // branch at pc=0x10 with delay slot
    step(0, 6'b000000, 0, 32'h0, 1, 32'h40, 32'h40, 1, 32'h10, 32'h1000_0004, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h44, 1, 32'h40, 32'h1000_0010, 0);
    step(0, 6'b000000, 0, 32'h0, 1, 32'h20, 32'h20, 1, 32'h44, 32'h1000_0011, 0);
    // full stall holds pc and IF/ID; branch ignored while stall[0]
    step(0, 6'b000111, 0, 32'h0, 1, 32'h80, 32'h20, 1, 32'h44, 32'h1000_0011, 0);
    step(0, 6'b000111, 0, 32'h0, 0, 32'h0, 32'h20, 1, 32'h44, 32'h1000_0011, 0);
    step(0, 6'b000111, 0, 32'h0, 0, 32'h0, 32'h20, 1, 32'h44, 32'h1000_0011, 0);
    // IF stalled, ID running: pc holds, bubble into ID
    step(0, 6'b000011, 0, 32'h0, 0, 32'h0, 32'h20, 1, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h24, 1, 32'h20, 32'h1000_0008, 0);
    // flush beats stall and branch
    step(0, 6'b000111, 1, 32'h180, 1, 32'h40, 32'h180, 1, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h184, 1, 32'h180, 32'h1000_0060, 0);
    // misaligned target
    step(0, 6'b000000, 0, 32'h0, 1, 32'h42, 32'h42, 1, 32'h184, 32'h1000_0061, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h46, 1, 32'h42, 32'h0, 1);
    // pc+4 wrap
    step(0, 6'b000000, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h46, 32'h0, 1);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h4, 1, 32'h0, 32'h1000_0000, 0);
    // stall[1] alone: pc advances, bubble into ID
    step(0, 6'b000010, 0, 32'h0, 0, 32'h0, 32'h8, 1, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'hC, 1, 32'h8, 32'h1000_0002, 0);
    // reset pulse discards pending branch
    step(1, 6'b000000, 0, 32'h0, 1, 32'h40, 32'h0, 0, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h0, 1, 32'h0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h4, 1, 32'h0, 32'h1000_0000, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 32'h0, 32'h8, 1, 32'h4, 32'h1000_0001, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
